// File: rtl/contador_pkg.sv
// Shared types and defaults for the up-counter timer/sequencer.
package contador_pkg;

  localparam int BITS_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } st_e;

endpackage

// File: rtl/contador_dp.sv
// Count/limit registers: load clears the count and latches the limit, inc advances
// the count, otherwise both hold.
module contador_dp
  import contador_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            inc,
  input  logic [BITS-1:0] limit_in,
  output logic [BITS-1:0] cuenta,
  output logic            match
);

  logic [BITS-1:0] lim_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cuenta <= '0;
      lim_q  <= '0;
    end else if (load) begin
      cuenta <= '0;
      lim_q  <= limit_in;
    end else if (inc) begin
      cuenta <= cuenta + 1'b1;
    end
  end

  assign match = (cuenta == lim_q);

endmodule

// File: rtl/contador_arriba_tc.sv
// Up-counter with enable and latched terminal count, sequenced by an IDLE/COUNT/DONE
// FSM; busy and done are Moore outputs decoded from the state register.
module contador_arriba_tc
  import contador_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            EN,
  input  logic            start,
  input  logic [BITS-1:0] limit,
  output logic [BITS-1:0] cuenta,
  output logic            busy,
  output logic            done
);

  st_e  state_q, state_d;
  logic load, inc, match;

  // Terminal check precedes the increment, so a limit of all-ones never wraps.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d = state_q;
    load    = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (EN) begin
          if (match) state_d = DONE;
          else       inc     = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  contador_dp #(.BITS(BITS)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .inc      (inc),
    .limit_in (limit),
    .cuenta   (cuenta),
    .match    (match)
  );

  assign busy = (state_q == COUNT);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_contador_arriba_tc.sv
// Scoreboard bench for contador_arriba_tc: each scenario pushes the expected
// {cuenta, busy, done} as it drives a cycle and pops it once the DUT has clocked.
module tb_contador_arriba_tc;

  localparam int BITS = 3;

  typedef struct packed {
    logic [BITS-1:0] cuenta;
    logic            busy;
    logic            done;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b0;
  logic            start = 1'b0;
  logic [BITS-1:0] limit = '0;
  logic [BITS-1:0] cuenta;
  logic            busy;
  logic            done;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  contador_arriba_tc #(.BITS(BITS)) dut (
    .clk    (clk),
    .rst    (rst),
    .EN     (en),
    .start  (start),
    .limit  (limit),
    .cuenta (cuenta),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int c, input logic b, input logic d);
    exp_t e;
    e.cuenta = c[BITS-1:0];
    e.busy   = b;
    e.done   = d;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    sb.push_back(mk(0, 1'b0, 1'b0));
    #1;
    e = sb.pop_front();
    n_cmp++;
    if ({cuenta, busy, done} !== e) begin
      n_err++;
      $display("FAIL reset_async: got cuenta=%0d busy=%b done=%b, want cuenta=%0d busy=%b done=%b",
               cuenta, busy, done, e.cuenta, e.busy, e.done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      en = 1'b1; start = 1'b0; limit = 3'd4;
      sb.push_back(mk(0, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if ({cuenta, busy, done} !== e) begin
        n_err++;
        $display("FAIL reset_idle c%0d: got cuenta=%0d busy=%b done=%b, want cuenta=%0d busy=%b done=%b",
                 c, cuenta, busy, done, e.cuenta, e.busy, e.done);
      end
    end
  endtask

  task automatic test_full_run();
    exp_t e;
    for (int c = 0; c < 9; c++) begin
      en = 1'b1; start = (c == 0); limit = 3'd5;
      if (c <= 5)      sb.push_back(mk(c, 1'b1, 1'b0));
      else if (c == 6) sb.push_back(mk(5, 1'b0, 1'b1));
      else             sb.push_back(mk(5, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if ({cuenta, busy, done} !== e) begin
        n_err++;
        $display("FAIL full_run c%0d: got cuenta=%0d busy=%b done=%b, want cuenta=%0d busy=%b done=%b",
                 c, cuenta, busy, done, e.cuenta, e.busy, e.done);
      end
    end
  endtask

  task automatic test_pause();
    exp_t e;
    // Unpaused, done would appear after c4; two EN=0 cycles push it to c6.
    for (int c = 0; c < 8; c++) begin
      en = !(c == 2 || c == 3); start = (c == 0); limit = 3'd3;
      if (c == 0)      sb.push_back(mk(0, 1'b1, 1'b0));
      else if (c <= 3) sb.push_back(mk(1, 1'b1, 1'b0));
      else if (c <= 5) sb.push_back(mk(c - 2, 1'b1, 1'b0));
      else if (c == 6) sb.push_back(mk(3, 1'b0, 1'b1));
      else             sb.push_back(mk(3, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if ({cuenta, busy, done} !== e) begin
        n_err++;
        $display("FAIL pause c%0d: got cuenta=%0d busy=%b done=%b, want cuenta=%0d busy=%b done=%b",
                 c, cuenta, busy, done, e.cuenta, e.busy, e.done);
      end
    end
  endtask

  task automatic test_edge_limits();
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      en = 1'b1; start = (c == 0); limit = 3'd0;
      sb.push_back(mk(0, c == 0, c == 1));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if ({cuenta, busy, done} !== e) begin
        n_err++;
        $display("FAIL limit0 c%0d: got cuenta=%0d busy=%b done=%b, want cuenta=%0d busy=%b done=%b",
                 c, cuenta, busy, done, e.cuenta, e.busy, e.done);
      end
    end
    for (int c = 0; c < 10; c++) begin
      en = 1'b1; start = (c == 0); limit = 3'd7;
      if (c <= 7)      sb.push_back(mk(c, 1'b1, 1'b0));
      else if (c == 8) sb.push_back(mk(7, 1'b0, 1'b1));
      else             sb.push_back(mk(7, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if ({cuenta, busy, done} !== e) begin
        n_err++;
        $display("FAIL limit7 c%0d: got cuenta=%0d busy=%b done=%b, want cuenta=%0d busy=%b done=%b",
                 c, cuenta, busy, done, e.cuenta, e.busy, e.done);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    // Run to 4 with start/limit wiggled mid-run, then start held across DONE.
    for (int c = 0; c < 12; c++) begin
      en    = 1'b1;
      start = (c == 0) || (c == 1) || (c >= 5 && c <= 7);
      limit = (c == 0) ? 3'd4 : (c < 5) ? 3'd1 : 3'd2;
      if (c <= 4)       sb.push_back(mk(c, 1'b1, 1'b0));
      else if (c == 5)  sb.push_back(mk(4, 1'b0, 1'b1));
      else if (c == 6)  sb.push_back(mk(4, 1'b0, 1'b0));
      else if (c <= 9)  sb.push_back(mk(c - 7, 1'b1, 1'b0));
      else if (c == 10) sb.push_back(mk(2, 1'b0, 1'b1));
      else              sb.push_back(mk(2, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if ({cuenta, busy, done} !== e) begin
        n_err++;
        $display("FAIL back_to_back c%0d: got cuenta=%0d busy=%b done=%b, want cuenta=%0d busy=%b done=%b",
                 c, cuenta, busy, done, e.cuenta, e.busy, e.done);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      en = 1'b1; start = (c == 0); limit = 3'd6;
      sb.push_back(mk(c, 1'b1, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if ({cuenta, busy, done} !== e) begin
        n_err++;
        $display("FAIL mid_run_pre c%0d: got cuenta=%0d busy=%b done=%b, want cuenta=%0d busy=%b done=%b",
                 c, cuenta, busy, done, e.cuenta, e.busy, e.done);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    sb.push_back(mk(0, 1'b0, 1'b0));
    #1;
    e = sb.pop_front();
    n_cmp++;
    if ({cuenta, busy, done} !== e) begin
      n_err++;
      $display("FAIL mid_run_rst: got cuenta=%0d busy=%b done=%b, want cuenta=%0d busy=%b done=%b",
               cuenta, busy, done, e.cuenta, e.busy, e.done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      en = 1'b1; start = (c == 0); limit = 3'd2;
      if (c <= 2)      sb.push_back(mk(c, 1'b1, 1'b0));
      else if (c == 3) sb.push_back(mk(2, 1'b0, 1'b1));
      else             sb.push_back(mk(2, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = sb.pop_front();
      n_cmp++;
      if ({cuenta, busy, done} !== e) begin
        n_err++;
        $display("FAIL mid_run_restart c%0d: got cuenta=%0d busy=%b done=%b, want cuenta=%0d busy=%b done=%b",
                 c, cuenta, busy, done, e.cuenta, e.busy, e.done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_pause();
    test_edge_limits();
    test_back_to_back();
    test_reset_mid_run();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/contador_arriba_tc.md
# contador_arriba_tc

Up-counter with enable, latched terminal count and a three-state control FSM (IDLE/COUNT/DONE). It counts up from 0 to a programmed limit, then flags completion with a one-cycle pulse. It is the counting-up counterpart to the team's down-counter-with-enable. It sits in the state-machine section of the design as the timer/sequencer that upstream FSMs start and poll.

## Interface
Parameters:
- BITS, 3, width of count and limit.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- EN  in  1  count enable; when 0 the count holds.
- start  in  1  level-sampled request to begin a count run.
- limit  in  BITS  terminal value; sampled only on an accepted start.
- cuenta  out  BITS  current count, registered.
- busy  out  1  high in COUNT.
- done  out  1  one-cycle pulse, high in DONE.

## Operation
- States: IDLE, COUNT, DONE.
- Reset values: state=IDLE, cuenta=0, lim_q=0, busy=0, done=0. Reset is asynchronous and may occur mid-run; the run is abandoned.
- IDLE:
  - cuenta holds its last value (0 after reset).
  - start=1 accepts a run: lim_q<=limit, cuenta<=0, next state COUNT. EN is ignored in IDLE.
- COUNT:
  - EN=0: hold everything.
  - EN=1 with cuenta!=lim_q: cuenta<=cuenta+1 (modulo 2^BITS, unsigned).
  - EN=1 with cuenta==lim_q: cuenta holds at lim_q, next state DONE.
  - start is ignored; limit changes have no effect once latched.
- DONE: lasts exactly one cycle, then IDLE unconditionally. cuenta holds lim_q.
  - start=1 in DONE is ignored; a new run needs start in IDLE.
- limit=0: the first EN=1 cycle in COUNT goes to DONE with cuenta=0.
- limit=2^BITS-1: the count reaches the all-ones value and never wraps, because termination happens before the increment.
- Outputs are Moore, decoded from state: busy=(state==COUNT), done=(state==DONE).

## Timing
- Start acceptance: start high at edge k in IDLE gives COUNT and cuenta=0 visible after edge k.
- Each EN=1 edge in COUNT advances cuenta by 1.
- With EN held high and limit=L, busy is high for L+1 cycles. done pulses on the cycle after cuenta first shows L, and busy drops in that same cycle.
- Total from the start edge to the done pulse is L+1 cycles with EN continuously high; every EN=0 cycle adds one cycle.
- done is high for exactly one cycle, and busy and done are never high together.
- Back-to-back runs: start high during DONE is not accepted. It is accepted on the following IDLE cycle, so the minimum run spacing is L+3 cycles.

## Structure
- Package contador_pkg:
  - state enum typedef st_e {IDLE, COUNT, DONE}, 2-bit encoding.
  - default BITS constant.
- Sub-module contador_dp (BITS): holds the cuenta/lim_q registers and implements load/clear/increment/hold. Its inputs are load, inc and limit_in; its output is the match flag (cuenta==lim_q).
- The top holds the FSM, the output decode and the async-reset wiring into contador_dp.

## Test plan
- Reset then idle: assert rst mid-clock -> cuenta=0, busy=0, done=0 immediately and stay so with EN=1, start=0.
- Full run: limit=5, 1-cycle start, EN=1 -> cuenta 0,1,2,3,4,5 while busy=1 (6 cycles), then a single done pulse with cuenta=5, then IDLE holding 5.
- Pause: limit=3, EN low for 2 cycles after cuenta=1 -> cuenta holds 1 for 2 cycles; done arrives 2 cycles later than the unpaused case.
- Edge limits:
  - limit=0 -> done on the cycle after start with cuenta=0.
  - limit=7 (BITS=3) -> cuenta reaches 7, no wrap to 0, done follows.
- Ignored inputs: change limit to 1 and pulse start during COUNT (limit 4) -> run still ends at 4. start held high through DONE -> new run begins one cycle after DONE.
- Reset mid-run: rst at cuenta=2 of limit 6 -> immediate cuenta=0, IDLE. A new start then runs cleanly.
